note_spawner: RTL and testbench

- Consumes the 33-bit pseudo-random word from the free-running shift-register generator and turns it into timed arrow events for the playfield.
- Divides clk into beats. On each beat, decides whether to spawn a note and which of the 4 lanes it uses.
- Queues spawned notes in a small FIFO that the scroll/display stage drains through a valid/ready handshake.

---
 rtl/note_pkg.sv | 17 +
 rtl/note_fifo.sv | 70 +++++++
 rtl/note_spawner.sv | 120 ++++++++++++
 tb/tb_note_spawner.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// rtl/note_pkg.sv - shared lane types and spawn constants for the note spawner
package note_pkg;

    typedef logic [3:0] lane_mask_t;

    localparam logic [1:0] LANE_L = 2'd0;
    localparam logic [1:0] LANE_D = 2'd1;
    localparam logic [1:0] LANE_U = 2'd2;
    localparam logic [1:0] LANE_R = 2'd3;

    localparam logic [3:0] DOUBLE_MIN_DENSITY = 4'd6;

    function automatic lane_mask_t lane_bit(input logic [1:0] lane);
        lane_bit = lane_mask_t'(4'b0001 << lane);
    endfunction

endpackage

// File: rtl/note_fifo.sv
// rtl/note_fifo.sv - small lane-mask FIFO; a push into a full FIFO succeeds only alongside a pop
module note_fifo
    import note_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  lane_mask_t       i_data,
    output lane_mask_t       o_head,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level,
    output logic             o_drop
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    lane_mask_t       r_mem [DEPTH];

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the note.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_level = r_level;
    assign o_drop  = i_push && w_full && !w_pop;

endmodule

// File: rtl/note_spawner.sv
// rtl/note_spawner.sv - beat divider and random lane picker feeding a note FIFO
module note_spawner
    import note_pkg::*;
#(
    parameter int BEAT_DIV = 12500000,
    parameter int DEPTH    = 8,
    parameter int LVL_W    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [32:0]      random,
    input  logic [3:0]       density,
    output logic             note_valid,
    input  logic             note_ready,
    output logic [3:0]       note_lanes,
    output logic [15:0]      beat_count,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow
);

    localparam int DIV_W = (BEAT_DIV > 2) ? $clog2(BEAT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BEAT_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [15:0]      r_beat_count;
    logic [1:0]       r_last_lane;
    logic             r_overflow;

    logic             w_beat_tick;
    logic             w_spawn;
    logic             w_double;
    logic [1:0]       w_prim;
    logic [1:0]       w_lane;
    logic [1:0]       w_pair;
    lane_mask_t       w_mask;
    logic             w_push;
    logic             w_pop;
    lane_mask_t       w_head;
    logic             w_full;
    logic             w_empty;
    logic [LVL_W-1:0] w_level;
    logic             w_drop;
    logic             w_unused_random;

    assign w_unused_random = ^random[32:8];

    assign w_beat_tick = enable && (r_div_cnt == DIV_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (enable) begin
            r_div_cnt <= w_beat_tick ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_beat_count <= '0;
        end else if (w_beat_tick) begin
            r_beat_count <= r_beat_count + 16'd1;
        end
    end

    // Lane choice: never repeat the previous spawned lane; doubles pair opposite lanes.
    always_comb begin
        w_spawn  = ({1'b0, random[2:0]} < density);
        w_prim   = random[4:3];
        w_lane   = (w_prim == r_last_lane) ? w_prim + 2'd1 : w_prim;
        w_pair   = w_lane + 2'd2;
        w_double = (density >= DOUBLE_MIN_DENSITY) && (random[7:5] == 3'd0);
        w_mask   = lane_bit(w_lane);
        if (w_double) begin
            w_mask = w_mask | lane_bit(w_pair);
        end
    end

    assign w_push = w_beat_tick && w_spawn;
    assign w_pop  = note_valid && note_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_lane <= LANE_L;
        end else if (w_push) begin
            r_last_lane <= w_lane;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    note_fifo #(
        .DEPTH (DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_mask),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level),
        .o_drop  (w_drop)
    );

    assign note_valid = !w_empty;
    assign note_lanes = w_empty ? 4'b0000 : w_head;
    assign beat_count = r_beat_count;
    assign fifo_level = w_level;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_note_spawner.sv
// tb/tb_note_spawner.sv - scoreboard bench for note_spawner with BEAT_DIV=4, DEPTH=4
module tb_note_spawner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [32:0] random;
    logic [3:0]  density;
    logic        note_valid;
    logic        note_ready;
    logic [3:0]  note_lanes;
    logic [15:0] beat_count;
    logic [2:0]  fifo_level;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q [$];

    localparam logic [32:0] RND_SINGLE = 33'h20;
    localparam logic [32:0] RND_DOUBLE = 33'h10;

    note_spawner #(
        .BEAT_DIV (4),
        .DEPTH    (4),
        .LVL_W    (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .random     (random),
        .density    (density),
        .note_valid (note_valid),
        .note_ready (note_ready),
        .note_lanes (note_lanes),
        .beat_count (beat_count),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n    = 1'b0;
        enable     = 1'b0;
        note_ready = 1'b0;
        exp_q.delete();
        run(2);
        reset_n = 1'b1;
    endtask

    // Monitor: every accepted note is compared against the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (reset_n && note_valid && note_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_note: got %0h expected none", note_lanes);
                end else begin
                    chk("note_lanes", {28'd0, note_lanes}, {28'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        reset_n    = 1'b0;
        enable     = 1'b0;
        random     = '0;
        density    = '0;
        note_ready = 1'b0;
        #3;
        chk("rst_valid", {31'd0, note_valid}, 32'd0);
        chk("rst_lanes", {28'd0, note_lanes}, 32'd0);
        chk("rst_beat", {16'd0, beat_count}, 32'd0);
        chk("rst_level", {29'd0, fifo_level}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        run(2);
        reset_n = 1'b1;

        // Singles under no-repeat: 0010, 0001, 0010
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        enable = 1'b1; density = 4'd8; random = RND_SINGLE; note_ready = 1'b1;
        for (int b = 1; b <= 3; b++) begin
            run(4);
            chk("beat_count_p1", {16'd0, beat_count}, b);
        end

        density = 4'd0;
        run(40);
        chk("p2_beat", {16'd0, beat_count}, 32'd13);
        chk("p2_valid", {31'd0, note_valid}, 32'd0);
        chk("p2_level", {29'd0, fifo_level}, 32'd0);
        chk("p2_drained", exp_q.size(), 32'd0);

        // Stall downstream: fill to 4, then drops set overflow
        density = 4'd8; note_ready = 1'b0;
        for (int b = 1; b <= 6; b++) begin
            run(4);
            chk("p3_level", {29'd0, fifo_level}, (b < 4) ? b : 4);
            chk("p3_ovf", {31'd0, overflow}, (b >= 5) ? 1 : 0);
            chk("p3_head", {28'd0, note_lanes}, 32'b0001);
        end

        // Double note after reset: last_lane=0, p=2 -> lanes 2 and 0
        do_reset();
        exp_q.push_back(4'b0101);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        enable = 1'b1; density = 4'd6; random = RND_DOUBLE; note_ready = 1'b1;
        run(4);
        chk("dbl_lanes", {28'd0, note_lanes}, 32'b0101);
        density = 4'd8; random = RND_SINGLE;
        run(1);
        note_ready = 1'b0;
        run(3);
        for (int b = 0; b < 3; b++) run(4);
        chk("full_level", {29'd0, fifo_level}, 32'd4);
        chk("full_ovf", {31'd0, overflow}, 32'd0);
        run(3);
        note_ready = 1'b1;
        run(1);
        note_ready = 1'b0;
        chk("full_pushpop_level", {29'd0, fifo_level}, 32'd4);
        chk("full_pushpop_ovf", {31'd0, overflow}, 32'd0);
        chk("full_pushpop_head", {28'd0, note_lanes}, 32'b0010);

        // Enable gap: queue drains while the divider freezes mid-beat
        do_reset();
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        enable = 1'b1; density = 4'd8; random = RND_SINGLE; note_ready = 1'b0;
        run(8);
        chk("gap_level_pre", {29'd0, fifo_level}, 32'd2);
        run(2);
        enable = 1'b0; note_ready = 1'b1;
        run(20);
        chk("gap_beat", {16'd0, beat_count}, 32'd2);
        chk("gap_level", {29'd0, fifo_level}, 32'd0);
        chk("gap_valid", {31'd0, note_valid}, 32'd0);
        chk("gap_drained", exp_q.size(), 32'd0);
        exp_q.push_back(4'b0010);
        enable = 1'b1; note_ready = 1'b0;
        run(1);
        chk("resume_beat_hold", {16'd0, beat_count}, 32'd2);
        run(1);
        chk("resume_beat_tick", {16'd0, beat_count}, 32'd3);
        chk("resume_lanes", {28'd0, note_lanes}, 32'b0010);
        run(2);
        chk("pre_rst_valid", {31'd0, note_valid}, 32'd1);

        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_valid", {31'd0, note_valid}, 32'd0);
        chk("async_lanes", {28'd0, note_lanes}, 32'd0);
        chk("async_beat", {16'd0, beat_count}, 32'd0);
        chk("async_level", {29'd0, fifo_level}, 32'd0);
        chk("async_ovf", {31'd0, overflow}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
